addsub_serial_cc: RTL and testbench

Parametrised, multi-cycle integer add/subtract unit with condition-code generation for the execute stage. Operands of WIDTH bits are processed CHUNK bits per cycle through a registered ripple-carry slice, trading latency for a short critical path. Subtraction is a + ~b + 1. Results and the {OF, SF, ZF} condition codes return over a valid/ready handshake.

---
 rtl/addsub_serial_cc.sv | 144 ++++++++++++++
 tb/tb_addsub_serial_cc.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_serial_cc.sv
// ---------------------------------------------------------------------------
// addsub_serial_cc
//
// Multi-cycle integer add/subtract unit with condition codes. It processes
// WIDTH-bit operands CHUNK bits per cycle through one registered
// ripple-carry slice, so the critical path is one CHUNK-bit adder. It takes
// N = WIDTH/CHUNK cycles from acceptance to result. Subtraction is
// a + ~b + 1: the operand is inverted at load and the carry starts at 1.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds its payload while valid is high and ready
// is low. start_ready depends only on state and res_ready, never on
// start_valid. The unit can accept a new request in the same cycle it
// hands off a result, so back-to-back requests have no bubbles.
//
// Parameters:
//   WIDTH  operand/result width (>= 2)
//   CHUNK  bits processed per cycle; must divide WIDTH exactly
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   start_valid  request present
//   start_ready  unit can accept a request this cycle
//   op           0 = a + b, 1 = a - b
//   a, b         operands (two's complement), sampled only at acceptance
//   res_valid    result/cc/cout valid
//   res_ready    consumer accepts the result
//   result       sum or difference, modulo 2^WIDTH
//   cc           {OF, SF, ZF}
//   cout         carry out of bit WIDTH-1 (for subtract, 1 = no borrow)
// ---------------------------------------------------------------------------
module addsub_serial_cc #(
   parameter int WIDTH = 64,
   parameter int CHUNK = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] result,
   output logic [2:0]       cc,
   output logic             cout
);

   localparam int N  = WIDTH / CHUNK;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state, state_nxt;
   logic             accept;

   logic [WIDTH-1:0] opa, opb;     // latched operands; opb is already ~b for subtract
   logic             carry;        // carry into the current chunk
   logic [CW-1:0]    cnt;          // index of the chunk being added
   logic             nz_acc;       // any earlier chunk sum was nonzero

   logic [CHUNK-1:0] a_chk, b_chk, s_chk;
   logic             c_chk_out;
   logic             c_msb;
   logic             last;

   // ---------------------------------------------------------------------
   // Chunk slice
   // ---------------------------------------------------------------------
   always_comb begin
      a_chk = opa[int'(cnt)*CHUNK +: CHUNK];
      b_chk = opb[int'(cnt)*CHUNK +: CHUNK];
      {c_chk_out, s_chk} = {1'b0, a_chk} + {1'b0, b_chk} + {{CHUNK{1'b0}}, carry};
      // The sum bit is a ^ b ^ cin, so the carry into the MSB can be
      // recovered from the top bits without a separate (CHUNK-1)-bit adder.
      // This also works when CHUNK == 1.
      c_msb = a_chk[CHUNK-1] ^ b_chk[CHUNK-1] ^ s_chk[CHUNK-1];
      last  = (cnt == CW'(N - 1));
   end

   // ---------------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      start_ready = 1'b0;
      res_valid   = 1'b0;
      case (state)
         IDLE: begin
            start_ready = 1'b1;
            if (start_valid) state_nxt = BUSY;
         end
         BUSY: begin
            if (last) state_nxt = DONE;
         end
         DONE: begin
            res_valid   = 1'b1;
            start_ready = res_ready;
            if (res_ready) state_nxt = start_valid ? BUSY : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign accept = start_valid && start_ready;

   // ---------------------------------------------------------------------
   // Datapath
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opa    <= '0;
         opb    <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         nz_acc <= 1'b0;
         result <= '0;
         cc     <= 3'b000;
         cout   <= 1'b0;
      end else if (accept) begin
         opa    <= a;
         opb    <= op ? ~b : b;
         carry  <= op;
         cnt    <= '0;
         nz_acc <= 1'b0;
      end else if (state == BUSY) begin
         result[int'(cnt)*CHUNK +: CHUNK] <= s_chk;
         carry  <= c_chk_out;
         nz_acc <= nz_acc | (|s_chk);
         cnt    <= cnt + CW'(1);
         if (last) begin
            cout <= c_chk_out;
            cc   <= {c_msb ^ c_chk_out, s_chk[CHUNK-1], ~(nz_acc | (|s_chk))};
         end
      end
   end

endmodule

// File: tb/tb_addsub_serial_cc.sv
// ---------------------------------------------------------------------------
// tb_addsub_serial_cc
//
// Bench for addsub_serial_cc with three instances:
//   dut0: WIDTH=64, CHUNK=16 (N=4)  directed vectors, backpressure, reset
//   dut1: WIDTH=64, CHUNK=64 (N=1)  random ops against a full-width model
//   dut2: WIDTH=8,  CHUNK=2  (N=4)  random ops against a full-width model
// Inputs are driven, and outputs sampled, 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_addsub_serial_cc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // dut0
  logic        sv0 = 0, op0 = 0, rr0 = 0;
  logic [63:0] a0 = 0, b0 = 0;
  logic        sr0, rv0, co0;
  logic [63:0] res0;
  logic [2:0]  cc0;
  // dut1
  logic        sv1 = 0, op1 = 0, rr1 = 0;
  logic [63:0] a1 = 0, b1 = 0;
  logic        sr1, rv1, co1;
  logic [63:0] res1;
  logic [2:0]  cc1;
  // dut2
  logic        sv2 = 0, op2 = 0, rr2 = 0;
  logic [7:0]  a2 = 0, b2 = 0;
  logic        sr2, rv2, co2;
  logic [7:0]  res2;
  logic [2:0]  cc2;

  addsub_serial_cc #(.WIDTH(64), .CHUNK(16)) dut0 (
    .clk(clk), .rst(rst), .start_valid(sv0), .start_ready(sr0), .op(op0),
    .a(a0), .b(b0), .res_valid(rv0), .res_ready(rr0), .result(res0),
    .cc(cc0), .cout(co0));

  addsub_serial_cc #(.WIDTH(64), .CHUNK(64)) dut1 (
    .clk(clk), .rst(rst), .start_valid(sv1), .start_ready(sr1), .op(op1),
    .a(a1), .b(b1), .res_valid(rv1), .res_ready(rr1), .result(res1),
    .cc(cc1), .cout(co1));

  addsub_serial_cc #(.WIDTH(8), .CHUNK(2)) dut2 (
    .clk(clk), .rst(rst), .start_valid(sv2), .start_ready(sr2), .op(op2),
    .a(a2), .b(b2), .res_valid(rv2), .res_ready(rr2), .result(res2),
    .cc(cc2), .cout(co2));

  // selected instance view
  int          cur = 0;
  logic        cur_rv, cur_sr, cur_co;
  logic [63:0] cur_res;
  logic [2:0]  cur_cc;

  always_comb begin
    cur_rv = rv0; cur_sr = sr0; cur_co = co0; cur_res = res0; cur_cc = cc0;
    case (cur)
      1: begin cur_rv = rv1; cur_sr = sr1; cur_co = co1; cur_res = res1; cur_cc = cc1; end
      2: begin cur_rv = rv2; cur_sr = sr2; cur_co = co2; cur_res = {56'd0, res2}; cur_cc = cc2; end
      default: ;
    endcase
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int inst, input logic sv, input logic op,
                       input logic [63:0] a, input logic [63:0] b);
    case (inst)
      0: begin sv0 = sv; op0 = op; a0 = a; b0 = b; end
      1: begin sv1 = sv; op1 = op; a1 = a; b1 = b; end
      default: begin sv2 = sv; op2 = op; a2 = a[7:0]; b2 = b[7:0]; end
    endcase
  endtask

  task automatic set_rr(input int inst, input logic v);
    case (inst)
      0: rr0 = v;
      1: rr1 = v;
      default: rr2 = v;
    endcase
  endtask

  // Present a request for one edge, then scramble the operand inputs so a
  // unit that samples late would produce the wrong answer.
  task automatic launch(input int inst, input logic op, input logic [63:0] a,
                        input logic [63:0] b, input string tag);
    cur = inst;
    drive(inst, 1'b1, op, a, b);
    #0;
    check({tag, ".start_ready"}, 64'(cur_sr), 64'd1);
    tick();
    drive(inst, 1'b0, ~op, ~a, a ^ b);
  endtask

  // Wait (bounded) for res_valid, then check latency and payload.
  task automatic wait_check(input int exp_lat, input logic [63:0] exp_res,
                            input logic [2:0] exp_cc, input logic exp_co,
                            input string tag);
    int lat = 0;
    while (!cur_rv && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check({tag, ".result"}, cur_res, exp_res);
    check({tag, ".cc"}, 64'(cur_cc), 64'(exp_cc));
    check({tag, ".cout"}, 64'(cur_co), 64'(exp_co));
  endtask

  task automatic release_res(input int inst, input string tag);
    set_rr(inst, 1'b1);
    tick();
    set_rr(inst, 1'b0);
    check({tag, ".valid_drop"}, 64'(cur_rv), 64'd0);
  endtask

  task automatic do_op(input int inst, input logic op, input logic [63:0] a,
                       input logic [63:0] b, input int exp_lat,
                       input logic [63:0] exp_res, input logic [2:0] exp_cc,
                       input logic exp_co, input string tag);
    launch(inst, op, a, b, tag);
    wait_check(exp_lat, exp_res, exp_cc, exp_co, tag);
    release_res(inst, tag);
  endtask

  // Full-width reference: returns {cout, cc[2:0], result[63:0]}.
  function automatic logic [67:0] ref_model(input int w, input logic op,
                                            input logic [63:0] a, input logic [63:0] b);
    logic [63:0] m, r;
    logic [64:0] full;
    logic        sa, sb, sr, of;
    m    = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    full = {1'b0, a & m} + {1'b0, (op ? ~b : b) & m} + 65'(op);
    r    = full[63:0] & m;
    sa   = a[w-1];
    sb   = b[w-1];
    sr   = r[w-1];
    of   = op ? (sa != sb && sr != sa) : (sa == sb && sr != sa);
    return {full[w], of, sr, (r == 64'd0), r};
  endfunction

  initial begin
    logic [63:0] ra, rb;
    logic        rop;
    logic [67:0] e;

    // reset state
    #12;
    check("rst.res_valid", 64'(rv0), 64'd0);
    check("rst.result", res0, 64'd0);
    check("rst.cc", 64'(cc0), 64'd0);
    check("rst.cout", 64'(co0), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("rst.start_ready", 64'(sr0), 64'd1);

    // directed vectors, 64/16
    do_op(0, 1, 64'd5, 64'd5, 4, 64'd0, 3'b001, 1'b1, "sub5_5");
    do_op(0, 1, 64'd3, 64'd5, 4, 64'hFFFF_FFFF_FFFF_FFFE, 3'b010, 1'b0, "sub3_5");
    do_op(0, 1, 64'h8000_0000_0000_0000, 64'd1, 4, 64'h7FFF_FFFF_FFFF_FFFF, 3'b100, 1'b1, "sub_min_1");
    do_op(0, 0, 64'h0000_0000_FFFF_FFFF, 64'd1, 4, 64'h0000_0001_0000_0000, 3'b000, 1'b0, "add_xchunk");
    do_op(0, 0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4, 64'h8000_0000_0000_0000, 3'b110, 1'b0, "add_max_1");
    do_op(0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4, 64'd0, 3'b001, 1'b1, "add_wrap");

    // backpressure, then handshake overlapped with a new request
    launch(0, 0, 64'd5, 64'd6, "bp");
    wait_check(4, 64'd11, 3'b000, 1'b0, "bp");
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp.hold_valid", 64'(rv0), 64'd1);
      check("bp.hold_result", res0, 64'd11);
      check("bp.hold_cc", 64'(cc0), 64'd0);
      check("bp.hold_start_ready", 64'(sr0), 64'd0);
    end
    rr0 = 1'b1;
    drive(0, 1'b1, 1'b0, 64'd1, 64'd2);
    #0;
    check("bp.overlap_ready", 64'(sr0), 64'd1);
    tick();
    rr0 = 1'b0;
    drive(0, 1'b0, 1'b1, 64'hDEAD, 64'hBEEF);
    check("bp.valid_drop", 64'(rv0), 64'd0);
    wait_check(4, 64'd3, 3'b000, 1'b0, "bp2");
    release_res(0, "bp2");

    // reset two cycles into BUSY
    launch(0, 1, 64'd9, 64'd1, "abort");
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("abort.res_valid", 64'(rv0), 64'd0);
    check("abort.result", res0, 64'd0);
    check("abort.cc", 64'(cc0), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    check("abort.start_ready", 64'(sr0), 64'd1);
    do_op(0, 1, 64'd10, 64'd4, 4, 64'd6, 3'b000, 1'b1, "sub10_4");

    // random ops against the reference model
    for (int i = 0; i < 1000; i++) begin
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      rop = 1'($urandom_range(0, 1));
      e   = ref_model(64, rop, ra, rb);
      do_op(1, rop, ra, rb, 1, e[63:0], e[66:64], e[67], "rnd64x64");
    end
    for (int i = 0; i < 1000; i++) begin
      ra  = 64'($urandom_range(0, 255));
      rb  = 64'($urandom_range(0, 255));
      rop = 1'($urandom_range(0, 1));
      e   = ref_model(8, rop, ra, rb);
      do_op(2, rop, ra, rb, 4, e[63:0], e[66:64], e[67], "rnd8x2");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
